// File: rtl/ifu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifu_pkg                                                       |
// | Purpose  : Shared types and constants for the instruction fetch unit:    |
// |            FSM state encoding, reset PC default, bubble instruction and  |
// |            the fetch-buffer entry layout {addr, instr}.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ifu_pkg;

  // IDLE : no request outstanding
  // WAIT : request outstanding for the current fetch path
  // DROP : request outstanding whose data belongs to a flushed path
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } ifu_state_e;

  localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;
  localparam logic [31:0] c_nop_instr        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } ifu_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifu_fifo                                                      |
// | Purpose  : DEPTH-entry synchronous FIFO holding fetched {addr, instr}    |
// |            pairs. Flush empties it and wins over push/pop.               |
// | Ports    : clk_i, rst_i (async, active-low), flush_i, push_i, pop_i,     |
// |            push_data_i, head_o (oldest entry), count_o (occupancy).      |
// |            The caller never pushes when full or pops when empty.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  ifu_entry_t                   push_data_i,
  output ifu_entry_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  ifu_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (pop_i) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fetch_unit                                              |
// | Purpose  : Instruction fetch front end. Issues one word request at a     |
// |            time to a variable-latency instruction memory, buffers the    |
// |            responses and presents them in order to the IF/ID register.   |
// |            Redirects flush the buffer; an in-flight request from the old |
// |            path is drained in DROP and its data discarded.               |
// | Ports    : clk_i, rst_i (async, active-low)                              |
// |            redirect_i/redirect_pc_i        - branch/jump from decode     |
// |            imem_req_o/imem_addr_o          - memory request              |
// |            imem_ack_i/imem_data_i          - memory response             |
// |            out_valid_o/out_addr_o/out_instr_o/out_ready_i - to decode    |
// |            perf_fetch_cnt_o/perf_stall_cnt_o (IFU_PERF_CNT_EN only)      |
// | Config   : define IFU_PERF_CNT_EN to add the performance counters.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_reset_pc_default,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        out_valid_o,
  output logic [31:0] out_addr_o,
  output logic [31:0] out_instr_o,
  input  logic        out_ready_i
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  ifu_state_e    r_state;
  ifu_state_e    w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_nxt;
  logic [31:0]   w_redirect_pc;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_after;
  ifu_entry_t    w_head;
  ifu_entry_t    w_push_data;

  assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

  // Redirect overrides both same-cycle push and pop; the FIFO is flushed.
  assign w_valid       = (w_count != '0);
  assign w_pop         = w_valid & out_ready_i & ~redirect_i;
  assign w_push        = (r_state == ST_WAIT) & imem_ack_i & ~redirect_i;
  assign w_count_after = redirect_i ? '0 : (w_count + CW'(w_push) - CW'(w_pop));

  // In WAIT the outstanding request address always equals r_pc.
  assign w_push_data = '{addr: r_pc, instr: imem_data_i};

  ifu_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .push_data_i (w_push_data),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // r_addr is only loaded when a new request is issued, so it stays stable
  // across a DROP even though r_pc moves to the redirect target.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    case (r_state)
      ST_IDLE: begin
        if (redirect_i) begin
          w_pc_nxt = w_redirect_pc;
        end
        if (w_count_after < CW'(BUF_DEPTH)) begin
          w_state_nxt = ST_WAIT;
          w_addr_nxt  = w_pc_nxt;
        end
      end
      ST_WAIT: begin
        if (imem_ack_i) begin
          w_pc_nxt = redirect_i ? w_redirect_pc : (r_pc + 32'd4);
          if (w_count_after < CW'(BUF_DEPTH)) begin
            w_state_nxt = ST_WAIT;
            w_addr_nxt  = w_pc_nxt;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (redirect_i) begin
          w_state_nxt = ST_DROP;
          w_pc_nxt    = w_redirect_pc;
        end
      end
      ST_DROP: begin
        if (redirect_i) begin
          w_pc_nxt = w_redirect_pc;
        end
        // Buffer is empty here (flushed on entry, no pushes while dropping).
        if (imem_ack_i) begin
          w_state_nxt = ST_WAIT;
          w_addr_nxt  = w_pc_nxt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign imem_req_o  = (r_state != ST_IDLE);
  assign imem_addr_o = imem_req_o ? r_addr : '0;

  assign out_valid_o = w_valid;
  assign out_addr_o  = w_valid ? w_head.addr  : '0;
  assign out_instr_o = w_valid ? w_head.instr : c_nop_instr;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_valid && !out_ready_i) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = r_fetch_cnt;
  assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
